alu_arbiter: RTL

Two-requester arbiter and sequencer that shares a single `alu` instance between independent clients, for example a debug/FPGA front end and a test sequencer. It accepts operation requests, selects a winner by round-robin (or fixed) priority, and latches that winner's operands into the ALU. It then registers `portout` and the flags, and returns them with a one-cycle acknowledge. The block wraps `alu` through `alu_if` and presents a request/acknowledge port per client.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/alu_if.sv | 16 +
 rtl/alu.sv | 43 ++++
 rtl/alu_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: 32-bit machine word and the ALU operation code.
// Ports: none (package).
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

endpackage

// File: rtl/alu_if.sv
// Bundle between the ALU and whoever drives it.
// Signals: porta, portb, aluop (to ALU); portout, z_flag, n_flag, v_flag (from ALU).
interface alu_if;
  import cpu_types_pkg::*;

  word_t  porta;
  word_t  portb;
  aluop_t aluop;
  word_t  portout;
  logic   z_flag;
  logic   n_flag;
  logic   v_flag;

  modport alu  (input porta, portb, aluop, output portout, z_flag, n_flag, v_flag);
  modport ctrl (output porta, portb, aluop, input portout, z_flag, n_flag, v_flag);
endinterface

// File: rtl/alu.sv
// Purely combinational 32-bit ALU.
// Ports: aif (alu_if.alu) - operands and opcode in, result and z/n/v flags out.
// z_flag: result is zero; n_flag: result bit 31; v_flag: signed overflow on ADD/SUB only.
module alu
  import cpu_types_pkg::*;
(
  alu_if.alu aif
);

  word_t res;
  logic  ovf;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (aif.aluop)
      ALU_SLL:  res = aif.porta << aif.portb[4:0];
      ALU_SRL:  res = aif.porta >> aif.portb[4:0];
      ALU_ADD: begin
        res = aif.porta + aif.portb;
        // operands of equal sign producing a result of the other sign
        ovf = (aif.porta[31] == aif.portb[31]) && (res[31] != aif.porta[31]);
      end
      ALU_SUB: begin
        res = aif.porta - aif.portb;
        ovf = (aif.porta[31] != aif.portb[31]) && (res[31] != aif.porta[31]);
      end
      ALU_AND:  res = aif.porta & aif.portb;
      ALU_OR:   res = aif.porta | aif.portb;
      ALU_XOR:  res = aif.porta ^ aif.portb;
      ALU_NOR:  res = ~(aif.porta | aif.portb);
      ALU_SLT:  res = {31'b0, $signed(aif.porta) < $signed(aif.portb)};
      ALU_SLTU: res = {31'b0, aif.porta < aif.portb};
      default:  res = '0;
    endcase
  end

  assign aif.portout = res;
  assign aif.z_flag  = (res == '0);
  assign aif.n_flag  = res[31];
  assign aif.v_flag  = ovf;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer sharing one ALU.
// Ports:
//   CLK, nRST             clock, async active-low reset
//   req0/1, op0/1         request and opcode per requester
//   a0, b0, a1, b1        operands per requester
//   ack0/1                one-cycle acknowledge to the served requester
//   result, zero,
//   negative, overflow    registered ALU output of the last completed op
//   busy                  high while an op is in flight (EXEC/RESP)
//
// state | meaning
// IDLE  | waiting for a request; grants and latches operands
// EXEC  | ALU evaluates latched operands; result/flags captured
// RESP  | ack pulses for the granted requester; last winner recorded
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   req0,
  input  logic   req1,
  input  aluop_t op0,
  input  aluop_t op1,
  input  word_t  a0,
  input  word_t  b0,
  input  word_t  a1,
  input  word_t  b1,
  output logic   ack0,
  output logic   ack1,
  output word_t  result,
  output logic   zero,
  output logic   negative,
  output logic   overflow,
  output logic   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  aluop_t opreg;
  word_t  areg;
  word_t  breg;
  logic   sel;
  logic   last;
  logic   winner;

  alu_if aif ();

  alu u_alu (.aif(aif.alu));

  assign aif.porta = areg;
  assign aif.portb = breg;
  assign aif.aluop = opreg;

  // Only meaningful when at least one request is high.
  always_comb begin
    winner = 1'b0;
    if (FAIR) begin
      if (req0 && req1) winner = ~last;
      else              winner = req1;
    end else begin
      winner = ~req0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      opreg    <= ALU_SLL;
      areg     <= '0;
      breg     <= '0;
      sel      <= 1'b0;
      last     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel   <= winner;
            opreg <= winner ? op1 : op0;
            areg  <= winner ? a1  : a0;
            breg  <= winner ? b1  : b0;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          result   <= aif.portout;
          zero     <= aif.z_flag;
          negative <= aif.n_flag;
          overflow <= aif.v_flag;
          // ack is registered here so it is high exactly during RESP
          ack0     <= ~sel;
          ack1     <= sel;
          state    <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          last  <= sel;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
